enemy_spawner: RTL
==================

ENEMY_SPAWNER -- requirements
Module: enemy_spawner

Interface
REQ-001 SPAWN_PERIOD, 5000000, cycles between spawn opportunities.
REQ-002 MAX_TRIES, 8, random cell probes per spawn attempt before giving up.
REQ-003 MAX_ENEMIES, 8, enemy population cap (used only with ENEMY_SPAWNER_CAP_EN).
REQ-004 LFSR_SEED, 16'hACE1, non-zero LFSR reset value.
REQ-005 One clock; reset is synchronous and active-high, ports named clock and reset.
REQ-006 clock  in  1  system clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 start  in  1  request one spawn pass; sampled only in WAIT.
REQ-009 done  out  1  one-cycle pulse ending every accepted pass.
REQ-010 spawned  out  1  one-cycle pulse, coincident with done, only when an enemy was written.
REQ-011 grid_x  out  6  grid column address, 0..39.
REQ-012 grid_y  out  5  grid row address, 0..29.
REQ-013 grid_out  in  3  cell value at (grid_x, grid_y), valid the cycle after the address is presented.
REQ-014 grid_write  out  1  write strobe to grid.
REQ-015 grid_in  out  3  value written when grid_write=1.

Function
REQ-016 Period counter SHALL count down from SPAWN_PERIOD-1 every cycle; at 0 it SHALL set sticky spawn_due and reload.
REQ-017 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle, never reach 0.
REQ-018 States: WAIT, PICK, READ, CHECK, WRITE, DONE (plus SCAN_ADDR, SCAN_READ with macro).
REQ-019 WAIT: start=1 and spawn_due=1 -> PICK (clear spawn_due, tries=0); start=1 and spawn_due=0 -> DONE with spawned=0; otherwise stay.
REQ-020 PICK: latch x = lfsr[5:0], minus 40 if >=40; y = lfsr[12:8], minus 30 if >=30; -> READ.
REQ-021 READ: hold address; -> CHECK.
REQ-022 CHECK: grid_out==AIR(0) -> WRITE; else tries+1; tries reaching MAX_TRIES -> DONE (spawned=0), else -> PICK.
REQ-023 WRITE: grid_write=1, grid_in=ENEMY(4) for exactly one cycle at latched (x,y); -> DONE.
REQ-024 DONE: done=1 for one cycle, spawned=1 iff WRITE visited this pass; -> WAIT.
REQ-025 grid_write SHALL be 0 and grid_in 0 in every state except WRITE; never more than one write per pass.
REQ-026 Latency: due spawn succeeding on first probe SHALL assert done 5 cycles after start is sampled; non-due start SHALL assert done next cycle.
REQ-027 start asserted outside WAIT SHALL be ignored; spawn_due set mid-pass SHALL remain pending for next start.
REQ-028 grid_x/grid_y SHALL never exceed 39/29.

Reset
REQ-029 Reset SHALL force WAIT, spawn_due=0, period counter=SPAWN_PERIOD-1, LFSR=LFSR_SEED, tries=0, all outputs 0 on the next edge, including mid-WRITE.

Configuration
REQ-030 Macro ENEMY_SPAWNER_CAP_EN defined: WAIT with due start -> SCAN_ADDR; scan all 1200 cells (2 cycles/cell, row-major from (0,0)), counting cells ==4, saturating at MAX_ENEMIES; count>=MAX_ENEMIES -> DONE (spawned=0), else -> PICK; pass latency adds 2400 cycles.
REQ-031 Macro undefined: no scan states or count logic; behaviour per REQ-019.

Structure
REQ-032 Shared include grid_defs.vh SHALL hold GRID_W=40, GRID_H=30, CELL_AIR=0, CELL_ENEMY=4, coordinate widths; shared with enemy_updater.
REQ-033 One sub-module spawn_lfsr (16-bit LFSR, seed parameter, free-running).

Verification
REQ-034 SPAWN_PERIOD=16, all-air grid, start held 1 after due -> one write of 4 to in-range cell, done+spawned 5 cycles after start.
REQ-035 start before first period expiry -> done next cycle, spawned=0, grid_write never 1.
REQ-036 Grid all walls (value 1), due start -> exactly 8 probes, no write, done with spawned=0.
REQ-037 Reset asserted in WRITE cycle -> next cycle grid_write=0, state WAIT, done never pulses.
REQ-038 CAP_EN, grid with 8 enemies, due start -> 2400-cycle scan, no write, spawned=0; with 7 enemies -> one write.
REQ-039 Run 10000 probes -> every grid_x<=39, grid_y<=29.

Source files
------------

// File: rtl/enemy_spawner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_spawner_pkg
//  Description : Shared grid definitions (dimensions, cell codes, coordinate
//                widths), the spawner state type and coordinate wrap helpers.
//                These grid definitions are shared with enemy_updater.
//  Config      : ENEMY_SPAWNER_CAP_EN adds the population-scan states.
//  Revision    : 1.0 - initial release
// ============================================================================
package enemy_spawner_pkg;

  localparam int GRID_W = 40;
  localparam int GRID_H = 30;
  localparam int X_W    = 6;
  localparam int Y_W    = 5;
  localparam int CELL_W = 3;

  localparam logic [CELL_W-1:0] CELL_AIR   = 3'd0;
  localparam logic [CELL_W-1:0] CELL_ENEMY = 3'd4;

`ifdef ENEMY_SPAWNER_CAP_EN
  typedef enum logic [2:0] {
    ST_WAIT, ST_PICK, ST_READ, ST_CHECK, ST_WRITE, ST_DONE,
    ST_SCAN_ADDR, ST_SCAN_READ
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_WAIT, ST_PICK, ST_READ, ST_CHECK, ST_WRITE, ST_DONE
  } state_t;
`endif

  // A 6-bit raw value is at most 63, so one conditional subtraction of 40
  // always lands in 0..39; likewise 31 - 30 for rows.
  function automatic logic [X_W-1:0] wrap_x(input logic [X_W-1:0] v);
    return (v >= X_W'(GRID_W)) ? v - X_W'(GRID_W) : v;
  endfunction

  function automatic logic [Y_W-1:0] wrap_y(input logic [Y_W-1:0] v);
    return (v >= Y_W'(GRID_H)) ? v - Y_W'(GRID_H) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_spawner_if.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_spawner_if
//  Description : Pass handshake and grid port bundle of the enemy spawner.
//  Ports       : start, done, spawned       - pass request / completion
//                grid_x, grid_y, grid_out   - grid read address and data
//                grid_write, grid_in        - grid write strobe and data
//  Modports    : master - the spawner;  slave - controller plus grid memory
//  Revision    : 1.0 - initial release
// ============================================================================
interface enemy_spawner_if;
  import enemy_spawner_pkg::*;

  logic              start;
  logic              done;
  logic              spawned;
  logic [X_W-1:0]    grid_x;
  logic [Y_W-1:0]    grid_y;
  logic [CELL_W-1:0] grid_out;
  logic              grid_write;
  logic [CELL_W-1:0] grid_in;

  modport master (
    input  start, grid_out,
    output done, spawned, grid_x, grid_y, grid_write, grid_in
  );

  modport slave (
    output start, grid_out,
    input  done, spawned, grid_x, grid_y, grid_write, grid_in
  );

endinterface
`default_nettype wire

// File: rtl/enemy_spawner_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : spawn_lfsr
//  Description : Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
//                (maximal length, so a non-zero seed never reaches zero).
//  Ports       : clock, reset (sync, active-high), value[15:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module spawn_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] value
);

  logic w_feedback;

  // Right-shifting form: tap n of the polynomial is bit (16 - n).
  assign w_feedback = value[0] ^ value[2] ^ value[3] ^ value[5];

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= SEED;
    end else begin
      value <= {w_feedback, value[15:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/enemy_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_spawner
//  Description : Periodically places an enemy (cell value 4) on a random air
//                cell of the 40x30 grid. A period counter raises a sticky
//                spawn_due flag; a start request with the flag set probes up
//                to MAX_TRIES random cells and writes the first air cell.
//  Ports       : clock, reset (sync, active-high)
//                bus (enemy_spawner_if.master): start, done, spawned,
//                grid_x, grid_y, grid_out, grid_write, grid_in
//  Config      : ENEMY_SPAWNER_CAP_EN - scan the whole grid first and skip
//                the spawn when MAX_ENEMIES enemies are already present.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_spawner
  import enemy_spawner_pkg::*;
#(
  parameter int          SPAWN_PERIOD = 5000000,
  parameter int          MAX_TRIES    = 8,
  parameter int          MAX_ENEMIES  = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic             clock,
  input logic             reset,
  enemy_spawner_if.master bus
);

  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [CNT_W-1:0] C_RELOAD   = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [TRY_W-1:0] C_LAST_TRY = TRY_W'(MAX_TRIES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_due;
  logic [TRY_W-1:0] r_tries;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic             r_done;
  logic             r_spawned;
  logic             r_write;

  logic [15:0]      w_lfsr;
  logic             w_accept;
  logic [X_W-1:0]   w_pick_x;
  logic [Y_W-1:0]   w_pick_y;
  logic             w_lfsr_unused;

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .value (w_lfsr)
  );

  assign w_pick_x      = wrap_x(w_lfsr[5:0]);
  assign w_pick_y      = wrap_y(w_lfsr[12:8]);
  assign w_lfsr_unused = ^{w_lfsr[15:13], w_lfsr[7:6]};
  assign w_accept      = (r_state == ST_WAIT) && bus.start && r_due;

  // Period counter and sticky due flag. A fresh expiry wins over the clear
  // on the same edge so that an opportunity is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= C_RELOAD;
      r_due <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt <= C_RELOAD;
      r_due <= 1'b1;
    end else begin
      r_cnt <= r_cnt - 1'b1;
      if (w_accept) begin
        r_due <= 1'b0;
      end
    end
  end

`ifdef ENEMY_SPAWNER_CAP_EN
  localparam int EN_W = $clog2(MAX_ENEMIES + 1);
  localparam logic [EN_W-1:0] C_CAP = EN_W'(MAX_ENEMIES);

  logic [EN_W-1:0] r_enemies;
  logic [EN_W-1:0] w_enemies_next;
  logic            w_last_cell;

  always_comb begin
    w_enemies_next = r_enemies;
    if ((bus.grid_out == CELL_ENEMY) && (r_enemies != C_CAP)) begin
      w_enemies_next = r_enemies + 1'b1;
    end
  end

  assign w_last_cell = (r_x == X_W'(GRID_W - 1)) && (r_y == Y_W'(GRID_H - 1));
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_WAIT;
      r_tries   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_done    <= 1'b0;
      r_spawned <= 1'b0;
      r_write   <= 1'b0;
`ifdef ENEMY_SPAWNER_CAP_EN
      r_enemies <= '0;
`endif
    end else begin
      // Pulse outputs default low; only the entering transition raises them.
      r_done    <= 1'b0;
      r_spawned <= 1'b0;
      r_write   <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (bus.start) begin
            if (r_due) begin
              r_tries <= '0;
`ifdef ENEMY_SPAWNER_CAP_EN
              r_x       <= '0;
              r_y       <= '0;
              r_enemies <= '0;
              r_state   <= ST_SCAN_ADDR;
`else
              r_state <= ST_PICK;
`endif
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_PICK: begin
          r_x     <= w_pick_x;
          r_y     <= w_pick_y;
          r_state <= ST_READ;
        end
        ST_READ: begin
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (bus.grid_out == CELL_AIR) begin
            r_write <= 1'b1;
            r_state <= ST_WRITE;
          end else if (r_tries == C_LAST_TRY) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_tries <= r_tries + 1'b1;
            r_state <= ST_PICK;
          end
        end
        ST_WRITE: begin
          r_done    <= 1'b1;
          r_spawned <= 1'b1;
          r_state   <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_WAIT;
        end
`ifdef ENEMY_SPAWNER_CAP_EN
        ST_SCAN_ADDR: begin
          r_state <= ST_SCAN_READ;
        end
        ST_SCAN_READ: begin
          r_enemies <= w_enemies_next;
          if (w_last_cell) begin
            if (w_enemies_next == C_CAP) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_PICK;
            end
          end else begin
            if (r_x == X_W'(GRID_W - 1)) begin
              r_x <= '0;
              r_y <= r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
            r_state <= ST_SCAN_ADDR;
          end
        end
`endif
        default: begin
          r_state <= ST_WAIT;
        end
      endcase
    end
  end

  assign bus.done       = r_done;
  assign bus.spawned    = r_spawned;
  assign bus.grid_x     = r_x;
  assign bus.grid_y     = r_y;
  assign bus.grid_write = r_write;
  assign bus.grid_in    = r_write ? CELL_ENEMY : CELL_AIR;

endmodule
`default_nettype wire
